// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for a Sobel kernel: two line buffers plus a
// three-column shift register turn a raster pixel stream into valid-only windows.
module sobel_window_gen #(
  parameter int IMAGE_ROW_SIZE    = 8,
  parameter int IMAGE_COLUMN_SIZE = 8,
  parameter int PIXEL_WIDTH       = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     pix_valid_i,
  input  logic [PIXEL_WIDTH-1:0]   pix_data_i,
  output logic                     pix_ready_o,
  output logic                     win_valid_o,
  output logic [9*PIXEL_WIDTH-1:0] win_data_o,
  input  logic                     win_ready_i,
  output logic                     win_last_o,
  output logic                     frame_done_o
);

  localparam int RW = (IMAGE_ROW_SIZE > 1) ? $clog2(IMAGE_ROW_SIZE) : 1;
  localparam int CW = (IMAGE_COLUMN_SIZE > 1) ? $clog2(IMAGE_COLUMN_SIZE) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(IMAGE_ROW_SIZE - 1);
  localparam logic [CW-1:0] C_LAST = CW'(IMAGE_COLUMN_SIZE - 1);

  typedef enum logic [1:0] {FILL, STREAM, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [RW-1:0]          r_q, r_d;
  logic [CW-1:0]          c_q, c_d;
  logic                   win_valid_q, win_valid_d;
  logic                   win_last_q, win_last_d;
  logic                   frame_done_q, frame_done_d;
  logic [PIXEL_WIDTH-1:0] lb0_q [IMAGE_COLUMN_SIZE];
  logic [PIXEL_WIDTH-1:0] lb1_q [IMAGE_COLUMN_SIZE];
  logic [PIXEL_WIDTH-1:0] win_q [9];
  logic [PIXEL_WIDTH-1:0] win_d [9];

  logic pix_acc, win_acc, at_row_end, at_frame_end, produce;

  // A pixel may only enter when no unaccepted window would be overwritten.
  assign pix_ready_o  = (state_q != DRAIN) && (!win_valid_q || win_ready_i);
  assign pix_acc      = pix_valid_i && pix_ready_o;
  assign win_acc      = win_valid_q && win_ready_i;
  assign at_row_end   = (c_q == C_LAST);
  assign at_frame_end = at_row_end && (r_q == R_LAST);
  assign produce      = pix_acc && (r_q >= RW'(2)) && (c_q >= CW'(2));

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    c_d          = c_q;
    win_valid_d  = win_valid_q;
    win_last_d   = win_last_q;
    frame_done_d = 1'b0;

    if (win_acc) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
    if (produce) begin
      win_valid_d = 1'b1;
      win_last_d  = at_frame_end;
    end

    if (pix_acc) begin
      if (at_row_end) begin
        c_d = '0;
        r_d = (r_q == R_LAST) ? '0 : r_q + RW'(1);
      end else begin
        c_d = c_q + CW'(1);
      end
    end

    case (state_q)
      FILL:    if (pix_acc && at_row_end && (r_q == RW'(1))) state_d = STREAM;
      STREAM:  if (pix_acc && at_frame_end) state_d = DRAIN;
      DRAIN: begin
        // The only window that can be pending here is the frame's last one.
        if (win_acc) begin
          state_d      = FILL;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    win_d = win_q;
    if (pix_acc) begin
      for (int row = 0; row < 3; row++) begin
        win_d[row*3]     = win_q[row*3 + 1];
        win_d[row*3 + 1] = win_q[row*3 + 2];
      end
      win_d[2] = lb1_q[c_q];
      win_d[5] = lb0_q[c_q];
      win_d[8] = pix_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= FILL;
      r_q          <= '0;
      c_q          <= '0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      c_q          <= c_d;
      win_valid_q  <= win_valid_d;
      win_last_q   <= win_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Pixel storage is never reset; window gating on r/c hides stale contents.
  always_ff @(posedge clk_i) begin
    win_q <= win_d;
    if (pix_acc) begin
      lb1_q[c_q] <= lb0_q[c_q];
      lb0_q[c_q] <= pix_data_i;
    end
  end

  always_comb begin
    win_data_o = '0;
    for (int k = 0; k < 9; k++) win_data_o[k*PIXEL_WIDTH +: PIXEL_WIDTH] = win_q[k];
  end

  assign win_valid_o  = win_valid_q;
  assign win_last_o   = win_last_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on an 8x8 ramp image (pixel = r*8 + c).
module tb_sobel_window_gen;

  logic        clk, rst, pix_valid, pix_ready, win_valid, win_ready, win_last, frame_done;
  logic [7:0]  pix_data;
  logic [71:0] win_data;

  int n_cmp = 0;
  int n_fail = 0;
  int rdy_mode = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int last_acc_cyc = -10;
  int fd_cyc = -20;
  int early_pix = 0;
  bit awaiting_fd = 1'b0;
  logic [71:0] obs_win[$];
  bit          obs_last[$];

  sobel_window_gen #(
    .IMAGE_ROW_SIZE(8), .IMAGE_COLUMN_SIZE(8), .PIXEL_WIDTH(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .pix_valid_i(pix_valid), .pix_data_i(pix_data),
    .pix_ready_o(pix_ready), .win_valid_o(win_valid), .win_data_o(win_data),
    .win_ready_i(win_ready), .win_last_o(win_last), .frame_done_o(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 1) win_ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (win_valid && win_ready) begin
      obs_win.push_back(win_data);
      obs_last.push_back(win_last);
      if (win_last) last_acc_cyc <= cyc;
    end
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_cyc <= cyc;
    end
    if (pix_valid && pix_ready && awaiting_fd && !frame_done) early_pix <= early_pix + 1;
    if (pix_valid && pix_ready && pix_data == 8'd63) awaiting_fd <= 1'b1;
    else if (frame_done) awaiting_fd <= 1'b0;
  end

  // Expected window n of a ramp frame: centre (1 + n/6, 1 + n%6).
  function automatic logic [71:0] exp_win(input int n);
    int m, rr, cc;
    logic [71:0] w;
    m  = n % 36;
    rr = 1 + m / 6;
    cc = 1 + m % 6;
    w  = '0;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'((rr - 1 + k / 3) * 8 + (cc - 1 + k % 3));
    return w;
  endfunction

  task automatic send_pixels(input int first, input int count, input int gap_max);
    for (int i = first; i < first + count; i++) begin
      int gaps;
      int guard;
      bit acc;
      gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      pix_valid = 1'b0;
      repeat (gaps) begin @(posedge clk); #1; end
      pix_valid = 1'b1;
      pix_data  = 8'(i % 64);
      guard = 0;
      acc   = 1'b0;
      while (!acc && guard < 1000) begin
        @(negedge clk);
        acc = pix_ready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!acc) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pixel_accept pixel=%0d actual=stuck required=accepted", i);
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int g;
    g = 0;
    while (fd_cnt < target && g < 600) begin
      @(posedge clk);
      #1;
      g++;
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1; pix_valid = 1'b0; pix_data = '0; win_ready = 1'b1; rdy_mode = 0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    n_cmp++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL rst_win_valid actual=%b required=0", win_valid); end
    n_cmp++; if (win_last !== 1'b0) begin n_fail++; $display("FAIL rst_win_last actual=%b required=0", win_last); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done actual=%b required=0", frame_done); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL rst_pix_ready actual=%b required=1", pix_ready); end
    n_cmp++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release_win_valid actual=%b required=0", win_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_ramp_frame;
    int base, fd0, nlast_bad;
    logic [71:0] w;
    base = obs_win.size(); fd0 = fd_cnt; rdy_mode = 0; win_ready = 1'b1;
    send_pixels(0, 18, 0);
    @(negedge clk);
    n_cmp++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL ramp_no_early_window actual=%b required=0", win_valid); end
    @(posedge clk); #1;
    send_pixels(18, 1, 0);
    @(negedge clk);
    n_cmp++; if (win_valid !== 1'b1) begin n_fail++; $display("FAIL ramp_first_valid actual=%b required=1", win_valid); end
    n_cmp++; if (win_data !== exp_win(0)) begin n_fail++; $display("FAIL ramp_first_data actual=%h required=%h", win_data, exp_win(0)); end
    @(posedge clk); #1;
    send_pixels(19, 45, 0);
    wait_done(fd0 + 1);
    n_cmp++; if (obs_win.size() - base != 36) begin n_fail++; $display("FAIL ramp_window_count actual=%0d required=36", obs_win.size() - base); end
    nlast_bad = 0;
    for (int i = 0; i < 36 && base + i < obs_win.size(); i++) begin
      n_cmp++; if (obs_win[base+i] !== exp_win(i)) begin n_fail++; $display("FAIL ramp_window_%0d actual=%h required=%h", i, obs_win[base+i], exp_win(i)); end
      if (obs_last[base+i] != (i == 35)) nlast_bad++;
    end
    n_cmp++; if (nlast_bad != 0) begin n_fail++; $display("FAIL ramp_last_flags actual=%0d_wrong required=0_wrong", nlast_bad); end
    w = (obs_win.size() > base + 35) ? obs_win[base+35] : '0;
    n_cmp++; if (w[71:64] !== 8'd63 || w[39:32] !== 8'd54) begin n_fail++; $display("FAIL ramp_last_k8_k4 actual=%0d,%0d required=63,54", w[71:64], w[39:32]); end
    n_cmp++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL ramp_frame_done_count actual=%0d required=1", fd_cnt - fd0); end
    n_cmp++; if (fd_cyc != last_acc_cyc + 1) begin n_fail++; $display("FAIL ramp_frame_done_timing actual=%0d required=%0d", fd_cyc, last_acc_cyc + 1); end
  endtask

  task automatic test_backpressure;
    int base, fd0;
    base = obs_win.size(); fd0 = fd_cnt; rdy_mode = 2; win_ready = 1'b1;
    send_pixels(0, 19, 0);
    win_ready = 1'b0;
    pix_valid = 1'b1;
    pix_data  = 8'd19;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL bp_pix_ready_%0d actual=%b required=0", i, pix_ready); end
      n_cmp++; if (win_valid !== 1'b1 || win_data !== exp_win(0)) begin n_fail++; $display("FAIL bp_hold_%0d actual=%b/%h required=1/%h", i, win_valid, win_data, exp_win(0)); end
    end
    @(posedge clk); #1;
    win_ready = 1'b1;
    send_pixels(19, 45, 0);
    wait_done(fd0 + 1);
    n_cmp++; if (obs_win.size() - base != 36) begin n_fail++; $display("FAIL bp_window_count actual=%0d required=36", obs_win.size() - base); end
    for (int i = 0; i < 36 && base + i < obs_win.size(); i++) begin
      n_cmp++; if (obs_win[base+i] !== exp_win(i)) begin n_fail++; $display("FAIL bp_window_%0d actual=%h required=%h", i, obs_win[base+i], exp_win(i)); end
    end
    n_cmp++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL bp_frame_done_count actual=%0d required=1", fd_cnt - fd0); end
    rdy_mode = 0;
  endtask

  task automatic test_random_gaps;
    int base, fd0, nlast_bad;
    base = obs_win.size(); fd0 = fd_cnt; rdy_mode = 1;
    send_pixels(0, 64, 3);
    wait_done(fd0 + 1);
    rdy_mode = 0;
    @(posedge clk); #1;
    win_ready = 1'b1;
    n_cmp++; if (obs_win.size() - base != 36) begin n_fail++; $display("FAIL rnd_window_count actual=%0d required=36", obs_win.size() - base); end
    nlast_bad = 0;
    for (int i = 0; i < 36 && base + i < obs_win.size(); i++) begin
      n_cmp++; if (obs_win[base+i] !== exp_win(i)) begin n_fail++; $display("FAIL rnd_window_%0d actual=%h required=%h", i, obs_win[base+i], exp_win(i)); end
      if (obs_last[base+i] != (i == 35)) nlast_bad++;
    end
    n_cmp++; if (nlast_bad != 0) begin n_fail++; $display("FAIL rnd_last_flags actual=%0d_wrong required=0_wrong", nlast_bad); end
    n_cmp++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL rnd_frame_done_count actual=%0d required=1", fd_cnt - fd0); end
  endtask

  task automatic test_reset_midframe;
    int base, fd0;
    rdy_mode = 0; win_ready = 1'b1;
    send_pixels(0, 30, 0);
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    base = obs_win.size(); fd0 = fd_cnt;
    @(negedge clk);
    n_cmp++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_win_valid actual=%b required=0", win_valid); end
    n_cmp++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_pix_ready actual=%b required=1", pix_ready); end
    @(posedge clk); #1;
    send_pixels(0, 64, 0);
    wait_done(fd0 + 1);
    n_cmp++; if (obs_win.size() - base != 36) begin n_fail++; $display("FAIL mid_window_count actual=%0d required=36", obs_win.size() - base); end
    for (int i = 0; i < 36 && base + i < obs_win.size(); i++) begin
      n_cmp++; if (obs_win[base+i] !== exp_win(i)) begin n_fail++; $display("FAIL mid_window_%0d actual=%h required=%h", i, obs_win[base+i], exp_win(i)); end
    end
    n_cmp++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL mid_frame_done_count actual=%0d required=1", fd_cnt - fd0); end
  endtask

  task automatic test_back_to_back;
    int base, fd0, early0, nlast_bad;
    base = obs_win.size(); fd0 = fd_cnt; early0 = early_pix; rdy_mode = 0; win_ready = 1'b1;
    send_pixels(0, 128, 0);
    wait_done(fd0 + 2);
    n_cmp++; if (obs_win.size() - base != 72) begin n_fail++; $display("FAIL b2b_window_count actual=%0d required=72", obs_win.size() - base); end
    nlast_bad = 0;
    for (int i = 0; i < 72 && base + i < obs_win.size(); i++) begin
      n_cmp++; if (obs_win[base+i] !== exp_win(i)) begin n_fail++; $display("FAIL b2b_window_%0d actual=%h required=%h", i, obs_win[base+i], exp_win(i)); end
      if (obs_last[base+i] != (i == 35 || i == 71)) nlast_bad++;
    end
    n_cmp++; if (nlast_bad != 0) begin n_fail++; $display("FAIL b2b_last_flags actual=%0d_wrong required=0_wrong", nlast_bad); end
    n_cmp++; if (fd_cnt - fd0 != 2) begin n_fail++; $display("FAIL b2b_frame_done_count actual=%0d required=2", fd_cnt - fd0); end
    n_cmp++; if (early_pix - early0 != 0) begin n_fail++; $display("FAIL b2b_pixel_before_done actual=%0d required=0", early_pix - early0); end
  endtask

  initial begin
    test_reset();
    test_ramp_frame();
    test_backpressure();
    test_random_gaps();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
